// File: rtl/writeback_regfile.sv
// Writeback stage: selects write data from the MEM/WB fields, commits it to a
// 32x32 register file with write-through read bypass, registers the last
// committed write for WB->EX forwarding, tracks halt and counts retired writes.
module writeback_regfile #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int NREGS = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wb_valid,
   input  logic [1:0]    memtoreg,
   input  logic          regwrite,
   input  logic [AW-1:0] wbDest,
   input  logic [DW-1:0] aluResult,
   input  logic [DW-1:0] dMemLoad,
   input  logic [DW-1:0] npc,
   input  logic [DW-1:0] upper16,
   input  logic          halt_in,
   input  logic [AW-1:0] rsel1,
   input  logic [AW-1:0] rsel2,
   output logic [DW-1:0] rdat1,
   output logic [DW-1:0] rdat2,
   output logic          fwd_valid,
   output logic [AW-1:0] fwd_dest,
   output logic [DW-1:0] fwd_data,
   output logic          halted,
   output logic [31:0]   wb_count
);

   typedef enum logic {
      S_RUN,
      S_HALTED
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [DW-1:0] regs [NREGS];
   logic [DW-1:0] wdata;
   logic          commit;

   // Write-data select from the MEM/WB result fields
   always_comb begin
      wdata = aluResult;
      case (memtoreg)
         2'b00:   wdata = aluResult;
         2'b01:   wdata = dMemLoad;
         2'b10:   wdata = npc;
         default: wdata = upper16;
      endcase
   end

   // Register 0 is never written; bubbles and a halted stage never commit
   assign commit = wb_valid & regwrite & (wbDest != '0) & (state == S_RUN);

   // Halt is sticky until reset
   always_comb begin
      state_next = state;
      if (state == S_RUN && wb_valid && halt_in) begin
         state_next = S_HALTED;
      end
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_RUN;
      end else begin
         state <= state_next;
      end
   end

   assign halted = (state == S_HALTED);

   // Register file storage
   always_ff @(posedge CLK) begin
      if (RST) begin
         regs <= '{default: '0};
      end else if (commit) begin
         regs[wbDest] <= wdata;
      end
   end

   // Last-committed-write register for WB->EX forwarding, plus retire counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         fwd_valid <= 1'b0;
         fwd_dest  <= '0;
         fwd_data  <= '0;
         wb_count  <= '0;
      end else begin
         fwd_valid <= commit;
         if (commit) begin
            fwd_dest <= wbDest;
            fwd_data <= wdata;
            wb_count <= wb_count + 32'd1;
         end
      end
   end

   // Read ports: r0 reads zero, a same-cycle commit to the index bypasses storage
   always_comb begin
      rdat1 = regs[rsel1];
      rdat2 = regs[rsel2];
      if (rsel1 == '0) begin
         rdat1 = '0;
      end else if (commit && wbDest == rsel1) begin
         rdat1 = wdata;
      end
      if (rsel2 == '0) begin
         rdat2 = '0;
      end else if (commit && wbDest == rsel2) begin
         rdat2 = wdata;
      end
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios followed by
// randomized traffic, all compared against a behavioural register-file model.
module tb_writeback_regfile;

   logic        CLK = 1'b0;
   logic        RST;
   logic        wb_valid;
   logic [1:0]  memtoreg;
   logic        regwrite;
   logic [4:0]  wbDest;
   logic [31:0] aluResult;
   logic [31:0] dMemLoad;
   logic [31:0] npc;
   logic [31:0] upper16;
   logic        halt_in;
   logic [4:0]  rsel1;
   logic [4:0]  rsel2;
   logic [31:0] rdat1;
   logic [31:0] rdat2;
   logic        fwd_valid;
   logic [4:0]  fwd_dest;
   logic [31:0] fwd_data;
   logic        halted;
   logic [31:0] wb_count;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_count;
   logic        m_halted;
   logic        m_fv;
   logic [4:0]  m_fd;
   logic [31:0] m_fdata;

   writeback_regfile #(.DW(32), .AW(5), .NREGS(32)) dut (
      .CLK(CLK), .RST(RST), .wb_valid(wb_valid), .memtoreg(memtoreg),
      .regwrite(regwrite), .wbDest(wbDest), .aluResult(aluResult),
      .dMemLoad(dMemLoad), .npc(npc), .upper16(upper16), .halt_in(halt_in),
      .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .halted(halted), .wb_count(wb_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_wdata();
      logic [31:0] v [4];
      v[0] = aluResult; v[1] = dMemLoad; v[2] = npc; v[3] = upper16;
      return v[memtoreg];
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] sel, input logic c, input logic [31:0] wd);
      if (sel == 5'd0) return 32'd0;
      if (c && wbDest == sel) return wd;
      return m_regs[sel];
   endfunction

   // One clock: check reads before the edge, advance model, check state after it
   task automatic step();
      logic [31:0] wd;
      logic        c;
      #2;
      wd = m_wdata();
      c  = wb_valid && regwrite && (wbDest != 5'd0) && !m_halted;
      check("rdat1", rdat1, m_read(rsel1, c, wd));
      check("rdat2", rdat2, m_read(rsel2, c, wd));
      @(posedge CLK);
      if (RST) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_count = 0; m_halted = 0; m_fv = 0; m_fd = 0; m_fdata = 0;
      end else begin
         m_fv = c;
         if (c) begin
            m_regs[wbDest] = wd;
            m_count = m_count + 1;
            m_fd = wbDest;
            m_fdata = wd;
         end
         if (wb_valid && halt_in) m_halted = 1'b1;
      end
      #1;
      check("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_fv});
      check("fwd_dest", {27'd0, fwd_dest}, {27'd0, m_fd});
      check("fwd_data", fwd_data, m_fdata);
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("wb_count", wb_count, m_count);
   endtask

   task automatic idle();
      RST = 0; wb_valid = 0; regwrite = 0; halt_in = 0; memtoreg = 0; wbDest = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 0; m_halted = 0; m_fv = 0; m_fd = 0; m_fdata = 0;
      idle();
      aluResult = 0; dMemLoad = 0; npc = 0; upper16 = 0; rsel1 = 0; rsel2 = 0;

      // 1. reset state
      RST = 1; step();
      idle(); rsel1 = 5; rsel2 = 31; step();
      check("t1_rdat1", rdat1, 32'd0);
      check("t1_count", wb_count, 32'd0);

      // 2. write r1..r4 through each memtoreg source
      aluResult = 32'h11; dMemLoad = 32'h22; npc = 32'h24; upper16 = 32'hABCD0000;
      wb_valid = 1; regwrite = 1;
      for (int i = 0; i < 4; i++) begin
         wbDest = 5'(i + 1); memtoreg = 2'(i); step();
      end
      idle(); rsel1 = 1; rsel2 = 2; step();
      check("t2_r1", rdat1, 32'h11);
      check("t2_r2", rdat2, 32'h22);
      rsel1 = 3; rsel2 = 4; step();
      check("t2_r3", rdat1, 32'h24);
      check("t2_r4", rdat2, 32'hABCD0000);
      check("t2_count", wb_count, 32'd4);

      // 3. write to r0 is discarded
      wb_valid = 1; regwrite = 1; wbDest = 0; memtoreg = 0; aluResult = 32'hFFFFFFFF;
      rsel1 = 0; step();
      check("t3_r0", rdat1, 32'd0);
      check("t3_fv", {31'd0, fwd_valid}, 32'd0);
      check("t3_count", wb_count, 32'd4);

      // 4. same-cycle bypass and forwarding
      wbDest = 7; aluResult = 32'hDEADBEEF; rsel1 = 7; #2;
      check("t4_bypass", rdat1, 32'hDEADBEEF);
      step();
      check("t4_fv", {31'd0, fwd_valid}, 32'd1);
      check("t4_fd", {27'd0, fwd_dest}, 32'd7);
      check("t4_fdata", fwd_data, 32'hDEADBEEF);

      // 5. halt with its own write, then writes ignored, reset clears halt
      wbDest = 9; aluResult = 32'd5; halt_in = 1; step();
      check("t5_halted", {31'd0, halted}, 32'd1);
      halt_in = 0; wbDest = 10; aluResult = 32'd6; rsel1 = 9; rsel2 = 10; step();
      check("t5_r9", rdat1, 32'd5);
      check("t5_r10", rdat2, 32'd0);
      check("t5_count", wb_count, 32'd6);
      idle(); RST = 1; step();
      check("t5_unhalt", {31'd0, halted}, 32'd0);

      // 6. bubble has no effect; reset beats a simultaneous commit
      idle(); regwrite = 1; wbDest = 3; aluResult = 32'h55; rsel1 = 3; step();
      check("t6_bubble", rdat1, 32'd0);
      wb_valid = 1; aluResult = 32'h77; RST = 1; step();
      idle(); rsel1 = 3; step();
      check("t6_r3", rdat1, 32'd0);
      check("t6_count", wb_count, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         RST       = ($urandom_range(0, 99) < 2);
         wb_valid  = ($urandom_range(0, 3) != 0);
         regwrite  = ($urandom_range(0, 4) != 0);
         halt_in   = ($urandom_range(0, 99) < 2);
         memtoreg  = 2'($urandom_range(0, 3));
         wbDest    = 5'($urandom_range(0, 31));
         aluResult = $urandom; dMemLoad = $urandom; npc = $urandom; upper16 = $urandom;
         rsel1     = ($urandom_range(0, 3) == 0) ? wbDest : 5'($urandom_range(0, 31));
         rsel2     = 5'($urandom_range(0, 31));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
